// File: rtl/fir_output_stage.sv
// FIR output stage: aligns the filter result to its i_ce strobe, rounds/scales/saturates
// to OUT_W bits, and buffers samples in a show-ahead ready/valid FIFO with debug counters.
module fir_output_stage #(
    parameter int unsigned IN_W   = 39,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SHIFT  = 15,
    parameter int unsigned CE_LAT = 2,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_ce,
    input  logic signed [IN_W-1:0]      i_result,
    input  logic                        i_flush,
    output logic signed [OUT_W-1:0]     o_sample,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [7:0]                  o_sat_cnt,
    output logic [7:0]                  o_ovf_cnt,
    output logic                        o_ovf,
    output logic [$clog2(DEPTH):0]      o_level
);

    localparam int unsigned SUM_W = IN_W + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic signed [SUM_W-1:0] RND    = SUM_W'(64'd1 << (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    logic [CE_LAT-1:0]        ce_sr_q, ce_sr_d;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]  s1_data_q, s1_data_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]         s2_data_q, s2_data_d;
    logic [OUT_W-1:0]         mem_q [DEPTH];
    logic [OUT_W-1:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic [OUT_W-1:0]         sample_q, sample_d;
    logic                     valid_q, valid_d;
    logic [7:0]               sat_cnt_q, sat_cnt_d;
    logic [7:0]               ovf_cnt_q, ovf_cnt_d;
    logic                     ovf_q, ovf_d;

    logic                     strobe_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  round_c;
    logic                     sat_c;
    logic [OUT_W-1:0]         clip_c;
    logic                     pop_c, full_c, wr_ok_c, drop_c;

    // Round half up on the sign-extended result, then saturate the scaled value
    always_comb begin
        strobe_c = ce_sr_q[CE_LAT-1];
        sum_c    = SUM_W'(i_result) + RND;
        round_c  = sum_c >>> SHIFT;
        sat_c    = 1'b0;
        clip_c   = OUT_W'(s1_data_q);
        if (s1_data_q > SAT_HI) begin
            sat_c  = 1'b1;
            clip_c = OUT_W'(SAT_HI);
        end else if (s1_data_q < SAT_LO) begin
            sat_c  = 1'b1;
            clip_c = OUT_W'(SAT_LO);
        end
    end

    always_comb begin
        pop_c   = valid_q && i_ready;
        full_c  = (level_q == LVL_W'(DEPTH));
        wr_ok_c = s2_valid_q && (!full_c || pop_c);
        drop_c  = s2_valid_q && full_c && !pop_c;

        ce_sr_d    = CE_LAT'({ce_sr_q, i_ce});
        s1_valid_d = strobe_c;
        s1_data_d  = strobe_c ? round_c : s1_data_q;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? clip_c : s2_data_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        sat_cnt_d  = sat_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        ovf_d      = ovf_q;

        if (i_flush) begin
            ce_sr_d    = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end else begin
            if (wr_ok_c) begin
                mem_d[wr_ptr_q] = s2_data_q;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_ok_c, pop_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (s1_valid_q && sat_c && (sat_cnt_q != 8'hFF)) begin
                sat_cnt_d = sat_cnt_q + 8'd1;
            end
            if (drop_c) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != 8'hFF) begin
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
                end
            end
        end

        // Head register follows the post-update FIFO so a same-cycle write is visible
        valid_d  = (level_d != '0);
        sample_d = valid_d ? mem_d[rd_ptr_d] : sample_q;
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ce_sr_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            sat_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ce_sr_q    <= ce_sr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            sat_cnt_q  <= sat_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_sample  = sample_q;
    assign o_valid   = valid_q;
    assign o_sat_cnt = sat_cnt_q;
    assign o_ovf_cnt = ovf_cnt_q;
    assign o_ovf     = ovf_q;
    assign o_level   = level_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed self-checking bench for fir_output_stage: vector table plus
// latency, overflow, full-with-read, flush and reset sequences.
module tb_fir_output_stage;

    localparam int unsigned CE_LAT = 2;

    logic               i_clk;
    logic               i_reset;
    logic               i_ce;
    logic signed [38:0] i_result;
    logic               i_flush;
    logic signed [15:0] o_sample;
    logic               o_valid;
    logic               i_ready;
    logic [7:0]         o_sat_cnt;
    logic [7:0]         o_ovf_cnt;
    logic               o_ovf;
    logic [3:0]         o_level;

    logic signed [38:0] cur_val;
    logic signed [38:0] res_dly [CE_LAT];

    int errors = 0;
    int checks = 0;

    fir_output_stage #(
        .IN_W(39), .OUT_W(16), .SHIFT(15), .CE_LAT(CE_LAT), .DEPTH(8)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_result(i_result),
        .i_flush(i_flush), .o_sample(o_sample), .o_valid(o_valid), .i_ready(i_ready),
        .o_sat_cnt(o_sat_cnt), .o_ovf_cnt(o_ovf_cnt), .o_ovf(o_ovf), .o_level(o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Filter model: result appears CE_LAT cycles after its i_ce
    always_ff @(posedge i_clk) begin
        res_dly[0] <= cur_val;
        for (int i = 1; i < int'(CE_LAT); i++) res_dly[i] <= res_dly[i-1];
    end
    assign i_result = res_dly[CE_LAT-1];

    typedef struct {
        logic signed [38:0] din;
        logic signed [15:0] exp;
        logic               sat;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic signed [38:0] val);
        cur_val = val;
        i_ce    = 1'b1;
        tick();
        i_ce    = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!o_valid && n < 12) begin
            tick();
            n++;
        end
        if (!o_valid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic drain_check(input string name, input int first, input int count);
        i_ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            check({name, "_valid"}, longint'(o_valid), 1);
            check({name, "_sample"}, longint'(o_sample), longint'(first + i));
            tick();
        end
        i_ready = 1'b0;
        check({name, "_level_end"}, longint'(o_level), 0);
        check({name, "_valid_end"}, longint'(o_valid), 0);
    endtask

    task automatic quiet_check(input string name);
        int seen;
        seen = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (o_valid) seen++;
            tick();
        end
        i_ready = 1'b0;
        check({name, "_no_emission"}, longint'(seen), 0);
    endtask

    int exp_sat;

    initial begin
        vecs[0]  = '{39'sd16384,          16'sd1,      1'b0};
        vecs[1]  = '{39'sd16383,          16'sd0,      1'b0};
        vecs[2]  = '{-39'sd16384,         16'sd0,      1'b0};
        vecs[3]  = '{-39'sd16385,         -16'sd1,     1'b0};
        vecs[4]  = '{-39'sd49152,         -16'sd1,     1'b0};
        vecs[5]  = '{39'sd3276800,        16'sd100,    1'b0};
        vecs[6]  = '{39'sd1073709056,     16'sd32767,  1'b0};
        vecs[7]  = '{-39'sd1073758208,    -16'sd32768, 1'b0};
        vecs[8]  = '{39'sd2147483648,     16'sd32767,  1'b1};
        vecs[9]  = '{-39'sd2147483648,    -16'sd32768, 1'b1};
        vecs[10] = '{39'sh3F_FFFF_FFFF,   16'sd32767,  1'b1};
        vecs[11] = '{39'sd1073725440,     16'sd32767,  1'b1};

        i_reset = 1'b1;
        i_ce    = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        cur_val = '0;
        @(negedge i_clk);
        tick();
        tick();
        i_reset = 1'b0;

        check("rst_valid",   longint'(o_valid),   0);
        check("rst_sample",  longint'(o_sample),  0);
        check("rst_level",   longint'(o_level),   0);
        check("rst_sat_cnt", longint'(o_sat_cnt), 0);
        check("rst_ovf_cnt", longint'(o_ovf_cnt), 0);
        check("rst_ovf",     longint'(o_ovf),     0);

        // First-sample latency: o_valid exactly CE_LAT+3 edges after i_ce
        push(39'sd32768);
        tick(); tick(); tick();
        check("lat_early_valid", longint'(o_valid), 0);
        tick();
        check("lat_valid",  longint'(o_valid),  1);
        check("lat_sample", longint'(o_sample), 1);
        check("lat_level",  longint'(o_level),  1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("lat_pop_valid", longint'(o_valid), 0);

        exp_sat = 0;
        for (int v = 0; v < 12; v++) begin
            push(vecs[v].din);
            wait_valid($sformatf("vec%0d", v));
            if (vecs[v].sat) exp_sat++;
            check($sformatf("vec%0d_sample", v), longint'(o_sample), longint'(vecs[v].exp));
            check($sformatf("vec%0d_sat_cnt", v), longint'(o_sat_cnt), longint'(exp_sat));
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            check($sformatf("vec%0d_popped", v), longint'(o_valid), 0);
        end

        // Overflow: 10 back-to-back samples into an 8-entry FIFO with no reads
        for (int k = 1; k <= 10; k++) push(39'(k) <<< 15);
        for (int i = 0; i < 6; i++) tick();
        check("ovf_level",   longint'(o_level),   8);
        check("ovf_flag",    longint'(o_ovf),     1);
        check("ovf_cnt",     longint'(o_ovf_cnt), 2);
        drain_check("ovf_drain", 1, 8);

        // Full FIFO: a read in the write cycle lets the write through
        for (int k = 1; k <= 8; k++) push(39'(k) <<< 15);
        for (int i = 0; i < 6; i++) tick();
        check("full_level", longint'(o_level), 8);
        push(39'sd9 <<< 15);
        tick(); tick(); tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("full_rw_level",   longint'(o_level),   8);
        check("full_rw_ovf_cnt", longint'(o_ovf_cnt), 2);
        drain_check("full_rw_drain", 2, 8);

        // Flush with 5 queued and 2 in flight
        for (int k = 1; k <= 5; k++) push(39'(k) <<< 15);
        for (int i = 0; i < 6; i++) tick();
        check("flush_pre_level", longint'(o_level), 5);
        push(39'sd6 <<< 15);
        push(39'sd7 <<< 15);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_level",   longint'(o_level),   0);
        check("flush_valid",   longint'(o_valid),   0);
        check("flush_sat_cnt", longint'(o_sat_cnt), longint'(exp_sat));
        check("flush_ovf_cnt", longint'(o_ovf_cnt), 2);
        check("flush_ovf",     longint'(o_ovf),     1);
        quiet_check("flush");

        // Same scenario with reset: counters and sticky flag also clear
        for (int k = 1; k <= 5; k++) push(39'(k) <<< 15);
        for (int i = 0; i < 6; i++) tick();
        check("mrst_pre_level", longint'(o_level), 5);
        push(39'sd6 <<< 15);
        push(39'sd7 <<< 15);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("mrst_level",   longint'(o_level),   0);
        check("mrst_valid",   longint'(o_valid),   0);
        check("mrst_sample",  longint'(o_sample),  0);
        check("mrst_sat_cnt", longint'(o_sat_cnt), 0);
        check("mrst_ovf_cnt", longint'(o_ovf_cnt), 0);
        check("mrst_ovf",     longint'(o_ovf),     0);
        quiet_check("mrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
